multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-002 SHALL have ports: op input 7, opcode of instruction register; zero input 1, ALU zero flag; mem_ready input 1, memory completes the current access this cycle.
REQ-003 SHALL have outputs: mem_req 1; AdrSrc 1 (0=PC, 1=ALUOut); IRWrite 1; PCWrite 1; MemWrite 1; RegWrite 1.
REQ-004 SHALL have outputs: ResultSrc 2 (00=ALUOut, 01=Data, 10=ALUResult); ALUSrcA 2 (00=PC, 01=OldPC, 10=rs1, 11=zero); ALUSrcB 2 (00=rs2, 01=ImmExt, 10=const 4); ALUOp 2; ImmSrc 3.
REQ-005 SHALL have outputs: illegal 1, sticky bad-opcode flag; state 4, current state code for debug.

Function
REQ-006 SHALL be a Moore FSM with codes FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, LUI=11, ERR=12; codes 13-15 SHALL go to FETCH on the next clock.
REQ-007 SHALL drive all outputs listed in REQ-003 and REQ-004 to 0 in every state unless listed below.
REQ-008 FETCH SHALL assert mem_req, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite SHALL be 1 only in the cycle mem_ready=1.
REQ-009 FETCH SHALL hold while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-010 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00, then branch on op: 0000011 or 0100011 to MEMADR; 0110011 to EXECR; 0010011 to EXECI; 1100011 to BEQ; 1101111 to JAL; 0110111 to LUI; any other value to ERR.
REQ-011 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, then go to MEMREAD if op=0000011, else MEMWRITE.
REQ-012 MEMREAD SHALL assert mem_req, AdrSrc=1, ResultSrc=00, hold until mem_ready=1, then go to MEMWB.
REQ-013 MEMWB SHALL assert RegWrite, ResultSrc=01, then go to FETCH.
REQ-014 MEMWRITE SHALL assert mem_req, AdrSrc=1, ResultSrc=00, and MemWrite on every cycle in the state, hold until mem_ready=1, then go to FETCH.
REQ-015 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=10; both SHALL go to ALUWB.
REQ-016 ALUWB SHALL assert RegWrite, ResultSrc=00, then go to FETCH.
REQ-017 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero (combinational), then go to FETCH.
REQ-018 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then go to ALUWB.
REQ-019 LUI SHALL drive ALUSrcA=11, ALUSrcB=01, ALUOp=00, then go to ALUWB.
REQ-020 ImmSrc SHALL be combinational from op in every state: 0100011 gives 001; 1100011 gives 010; 1101111 gives 011; 0110111 gives 100; all other op values give 000.
REQ-021 ERR SHALL keep all strobes 0 and remain in ERR until reset; illegal SHALL be 1 from the cycle after DECODE sees a bad op until reset.
REQ-022 Instruction latency in cycles, with zero memory wait: lw 5, sw 4, R/I 4, beq 3, jal 4, lui 4; each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE SHALL add exactly one cycle.
REQ-023 PCWrite, IRWrite, RegWrite and MemWrite SHALL never be asserted outside the states listed above.

Reset
REQ-024 With reset=1 at a rising edge, the block SHALL enter FETCH and clear illegal, from any state including mid-access waits.
REQ-025 After reset, outputs SHALL be the FETCH values, with IRWrite and PCWrite gated by mem_ready.
REQ-026 A memory access pending at reset SHALL be abandoned, with no MemWrite or RegWrite in the cycle after reset.

Verification
REQ-027 Test lw, op=0000011, mem_ready tied 1: states 0,1,2,3,4,0; RegWrite=1 with ResultSrc=01 only in state 4; ImmSrc=000.
REQ-028 Test sw with mem_ready=0 for 2 cycles in MEMWRITE: MemWrite=1 for 3 consecutive cycles, then FETCH; RegWrite never 1.
REQ-029 Test beq, op=1100011: zero=1 gives PCWrite=1 in state 9; zero=0 gives PCWrite=0; both return to FETCH after 3 cycles total.
REQ-030 Test fetch stall with mem_ready=0 for 3 cycles: state stays 0 and IRWrite=PCWrite=0; both pulse for exactly 1 cycle when mem_ready rises.
REQ-031 Test op=1111111: after DECODE, state=12 and illegal=1, held for 10+ cycles; reset=1 gives state=0 and illegal=0 on the next cycle.
REQ-032 Test reset asserted in MEMREAD during wait: next state=0, MemWrite=RegWrite=0; jal and lui sequences follow 0,1,10/11,8,0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle RISC-V datapath: sequences fetch, decode, memory,
// ALU and branch steps; one state per cycle, memory states stall on mem_ready=0.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_LUI      = 4'd11;
    localparam logic [3:0] S_ERR      = 4'd12;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    logic [3:0] r_state;
    logic       r_illegal;
    logic [3:0] w_next;

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    OP_LUI:       w_next = S_LUI;
                    default:      w_next = S_ERR;
                endcase
            end
            S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_LUI:      w_next = S_ALUWB;
            S_ERR:      w_next = S_ERR;
            default:    w_next = S_FETCH;
        endcase
    end

    // Reset abandons any pending access; illegal latches on the DECODE->ERR transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_DECODE) && (w_next == S_ERR))
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                RegWrite  = 1'b1;
                ResultSrc = 2'b01;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB:  RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = zero;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 3'b001;
            OP_BEQ:  ImmSrc = 3'b010;
            OP_JAL:  ImmSrc = 3'b011;
            OP_LUI:  ImmSrc = 3'b100;
            default: ImmSrc = 3'b000;
        endcase
    end

    assign illegal = r_illegal;
    assign state   = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through its state sequence.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic       illegal;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;
    int n_memw;
    int n_regw;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are observed 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1; op = 7'b0000011; zero = 1'b0; mem_ready = 1'b0;
        tick(); tick();
        check("rst_state", state, 0);
        check("rst_illegal", illegal, 0);
        check("rst_memreq", mem_req, 1);
        check("rst_irwrite_gated", IRWrite, 0);
        check("rst_pcwrite_gated", PCWrite, 0);
        check("rst_resultsrc", ResultSrc, 2);
        check("rst_alusrcb", ALUSrcB, 2);

        // lw, zero wait: 0,1,2,3,4,0
        reset = 1'b0; mem_ready = 1'b1; op = 7'b0000011; #1;
        check("lw_s0", state, 0);
        check("lw_irwrite", IRWrite, 1);
        check("lw_pcwrite", PCWrite, 1);
        check("lw_immsrc", ImmSrc, 0);
        tick(); check("lw_s1", state, 1); check("lw_dec_srca", ALUSrcA, 1);
        check("lw_dec_srcb", ALUSrcB, 1); check("lw_regw1", RegWrite, 0);
        tick(); check("lw_s2", state, 2); check("lw_adr_srca", ALUSrcA, 2);
        tick(); check("lw_s3", state, 3); check("lw_rd_adrsrc", AdrSrc, 1);
        check("lw_rd_memreq", mem_req, 1); check("lw_regw3", RegWrite, 0);
        tick(); check("lw_s4", state, 4); check("lw_wb_regw", RegWrite, 1);
        check("lw_wb_resultsrc", ResultSrc, 1);
        tick(); check("lw_back", state, 0); check("lw_regw0", RegWrite, 0);

        // sw with two wait cycles in MEMWRITE
        op = 7'b0100011; #1;
        check("sw_immsrc", ImmSrc, 1);
        n_memw = 0; n_regw = 0;
        tick(); check("sw_s1", state, 1);
        tick(); check("sw_s2", state, 2);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) begin mem_ready = 1'b1; #1; end
            check("sw_s5", state, 5);
            if (MemWrite) n_memw++;
            if (RegWrite) n_regw++;
        end
        tick();
        check("sw_back", state, 0);
        check("sw_memw_cycles", n_memw, 3);
        check("sw_regw_cycles", n_regw, 0);
        check("sw_memw_after", MemWrite, 0);

        // beq taken then not taken, 3 cycles each
        op = 7'b1100011;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            #1; check("beq_immsrc", ImmSrc, 2);
            tick(); check("beq_s1", state, 1);
            tick(); check("beq_s9", state, 9);
            check("beq_pcwrite", PCWrite, z);
            check("beq_aluop", ALUOp, 1);
            tick(); check("beq_back", state, 0);
        end
        zero = 1'b1; // PCWrite in BEQ follows zero combinationally
        tick(); tick(); check("beq_s9b", state, 9); check("beq_pcw_z1", PCWrite, 1);
        zero = 1'b0; #1; check("beq_pcw_z0", PCWrite, 0);
        tick(); check("beq_back2", state, 0);

        // fetch stall for 3 cycles, then lui sequence 0,1,11,8,0
        mem_ready = 1'b0; op = 7'b0110111; #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_state", state, 0);
            check("stall_irwrite", IRWrite, 0);
            check("stall_pcwrite", PCWrite, 0);
            tick();
        end
        check("stall_state3", state, 0);
        mem_ready = 1'b1; #1;
        check("stall_irw_pulse", IRWrite, 1);
        check("stall_pcw_pulse", PCWrite, 1);
        tick(); check("lui_s1", state, 1); check("stall_irw_off", IRWrite, 0);
        check("stall_pcw_off", PCWrite, 0);
        tick(); check("lui_s11", state, 11); check("lui_srca", ALUSrcA, 3);
        check("lui_immsrc", ImmSrc, 4);
        tick(); check("lui_s8", state, 8); check("lui_regw", RegWrite, 1);
        tick(); check("lui_back", state, 0);

        // jal 0,1,10,8,0
        op = 7'b1101111;
        tick(); check("jal_s1", state, 1);
        tick(); check("jal_s10", state, 10); check("jal_pcw", PCWrite, 1);
        check("jal_srcb", ALUSrcB, 2); check("jal_immsrc", ImmSrc, 3);
        tick(); check("jal_s8", state, 8);
        tick(); check("jal_back", state, 0);

        // R-type 0,1,6,8,0
        op = 7'b0110011;
        tick(); tick(); check("r_s6", state, 6); check("r_aluop", ALUOp, 2);
        check("r_srcb", ALUSrcB, 0);
        tick(); check("r_s8", state, 8);
        tick(); check("r_back", state, 0);

        // reset during MEMREAD wait
        op = 7'b0000011;
        tick(); tick(); mem_ready = 1'b0;
        tick(); check("mr_s3", state, 3);
        tick(); check("mr_hold", state, 3);
        reset = 1'b1;
        tick(); check("mr_rst_state", state, 0);
        check("mr_rst_memw", MemWrite, 0);
        check("mr_rst_regw", RegWrite, 0);
        reset = 1'b0; mem_ready = 1'b1;

        // illegal opcode
        op = 7'b1111111;
        tick(); check("ill_s1", state, 1); check("ill_pre", illegal, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("ill_state", state, 12);
            check("ill_flag", illegal, 1);
            check("ill_strobes", {mem_req, IRWrite, PCWrite, MemWrite, RegWrite}, 0);
        end
        reset = 1'b1;
        tick(); check("ill_rst_state", state, 0); check("ill_rst_flag", illegal, 0);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
